// File: rtl/mmu_arbiter_pkg.sv
// Shared types and constants for the two-master MMU request arbiter.
// Encodings match the legacy ARB_IDLE/ARB_BUSY/ARB_DONE values.
package mmu_arbiter_pkg;

  localparam int unsigned RegBusW = 32;
  localparam int unsigned RamBusW = 32;
  localparam int unsigned SelW    = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } arb_state_e;

  typedef enum logic {
    GrantM0 = 1'b0,
    GrantM1 = 1'b1
  } grant_e;

  typedef struct packed {
    logic               we;
    logic [RamBusW-1:0] addr;
    logic [RegBusW-1:0] data;
    logic [SelW-1:0]    sel;
  } req_t;

endpackage

// File: rtl/mmu_arbiter_if.sv
// Request/response bundle for mmu_arbiter. Suffixes are from the arbiter's view:
// slave is the arbiter itself, master is the surrounding requesters plus the MMU.
interface mmu_arbiter_if;
  import mmu_arbiter_pkg::*;

  logic               m0_ce_i, m0_we_i;
  logic [RamBusW-1:0] m0_addr_i;
  logic [RegBusW-1:0] m0_data_i;
  logic [SelW-1:0]    m0_sel_i;
  logic               m0_ready_o;
  logic [RegBusW-1:0] m0_data_o;
  logic               m0_tlb_err_o, m0_mod_o, m0_bus_err_o;

  logic               m1_ce_i, m1_we_i;
  logic [RamBusW-1:0] m1_addr_i;
  logic [RegBusW-1:0] m1_data_i;
  logic [SelW-1:0]    m1_sel_i;
  logic               m1_ready_o;
  logic [RegBusW-1:0] m1_data_o;
  logic               m1_err_o;

  logic               ce_o, we_o;
  logic [RamBusW-1:0] addr_o;
  logic [RegBusW-1:0] data_o;
  logic [SelW-1:0]    sel_o;
  logic               ready_i;
  logic [RegBusW-1:0] data_i;
  logic               tlb_err_i, mod_i;

  modport slave (
    input  m0_ce_i, m0_we_i, m0_addr_i, m0_data_i, m0_sel_i,
    output m0_ready_o, m0_data_o, m0_tlb_err_o, m0_mod_o, m0_bus_err_o,
    input  m1_ce_i, m1_we_i, m1_addr_i, m1_data_i, m1_sel_i,
    output m1_ready_o, m1_data_o, m1_err_o,
    output ce_o, we_o, addr_o, data_o, sel_o,
    input  ready_i, data_i, tlb_err_i, mod_i
  );

  modport master (
    output m0_ce_i, m0_we_i, m0_addr_i, m0_data_i, m0_sel_i,
    input  m0_ready_o, m0_data_o, m0_tlb_err_o, m0_mod_o, m0_bus_err_o,
    output m1_ce_i, m1_we_i, m1_addr_i, m1_data_i, m1_sel_i,
    input  m1_ready_o, m1_data_o, m1_err_o,
    input  ce_o, we_o, addr_o, data_o, sel_o,
    output ready_i, data_i, tlb_err_i, mod_i
  );

endinterface

// File: rtl/mmu_arbiter_arb_starve_ctr.sv
// Saturating count of port-0 grants taken while port 1 waits; sat forces port 1 next.
module arb_starve_ctr #(
  parameter int unsigned Max = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int unsigned CntW = (Max > 0) ? $clog2(Max + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign sat_o = (cnt_q == CntW'(Max));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mmu_arbiter.sv
// Two-master arbiter in front of the single MMU port: fixed priority to port 0 with a
// starvation override for port 1. Optional BUSY watchdog under MMU_ARB_TIMEOUT_EN.
module mmu_arbiter
  import mmu_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX  = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic          clk,
  input logic          rst,
  mmu_arbiter_if.slave bus
);

  arb_state_e         state_q;
  grant_e             grant_q;
  logic               starve_sat, pick_m1, pick_m0, timeout, finish;
  logic [RegBusW-1:0] rd_data;
  req_t               win_req;

  assign pick_m1 = bus.m1_ce_i && (starve_sat || !bus.m0_ce_i);
  assign pick_m0 = !pick_m1 && bus.m0_ce_i;

  arb_starve_ctr #(
    .Max (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc_i ((state_q == StIdle) && pick_m0 && bus.m1_ce_i),
    .clr_i ((state_q == StIdle) && pick_m1),
    .sat_o (starve_sat)
  );

`ifdef MMU_ARB_TIMEOUT_EN
  localparam int unsigned TimerW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  logic [TimerW-1:0] timer_q;

  // A ready on the deadline cycle wins over the abort.
  assign timeout = (state_q == StBusy) && !bus.ready_i && (timer_q == TimerW'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst || state_q != StBusy) begin
      timer_q <= '0;
    end else if (!bus.ready_i && !timeout) begin
      timer_q <= timer_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  assign finish  = bus.ready_i || timeout;
  assign rd_data = (bus.we_o || timeout) ? '0 : bus.data_i;

  always_comb begin
    if (pick_m1) begin
      win_req = {bus.m1_we_i, bus.m1_addr_i, bus.m1_data_i, bus.m1_sel_i};
    end else begin
      win_req = {bus.m0_we_i, bus.m0_addr_i, bus.m0_data_i, bus.m0_sel_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      grant_q          <= GrantM0;
      bus.ce_o         <= 1'b0;
      bus.we_o         <= 1'b0;
      bus.addr_o       <= '0;
      bus.data_o       <= '0;
      bus.sel_o        <= '0;
      bus.m0_ready_o   <= 1'b0;
      bus.m0_data_o    <= '0;
      bus.m0_tlb_err_o <= 1'b0;
      bus.m0_mod_o     <= 1'b0;
      bus.m0_bus_err_o <= 1'b0;
      bus.m1_ready_o   <= 1'b0;
      bus.m1_data_o    <= '0;
      bus.m1_err_o     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_m1 || pick_m0) begin
            state_q    <= StBusy;
            grant_q    <= pick_m1 ? GrantM1 : GrantM0;
            bus.ce_o   <= 1'b1;
            bus.we_o   <= win_req.we;
            bus.addr_o <= win_req.addr;
            bus.data_o <= win_req.data;
            bus.sel_o  <= win_req.sel;
          end
        end
        StBusy: begin
          if (finish) begin
            state_q  <= StDone;
            bus.ce_o <= 1'b0;
            if (grant_q == GrantM1) begin
              bus.m1_ready_o <= 1'b1;
              bus.m1_data_o  <= rd_data;
              bus.m1_err_o   <= bus.tlb_err_i || timeout;
            end else begin
              bus.m0_ready_o   <= 1'b1;
              bus.m0_data_o    <= rd_data;
              bus.m0_tlb_err_o <= bus.tlb_err_i && !timeout;
              bus.m0_mod_o     <= bus.mod_i && !timeout;
              bus.m0_bus_err_o <= timeout;
            end
          end
        end
        StDone: begin
          // Turnaround cycle: no arbitration, so a requester dropping ce is not re-granted.
          state_q        <= StIdle;
          bus.m0_ready_o <= 1'b0;
          bus.m1_ready_o <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
